// File: rtl/mips_regwrite_arbiter.sv
// rtl/mips_regwrite_arbiter.sv - write-port scheduler for the 8x32 mips register file
// Clears every register after reset, then round-robins the single write port between A and B.
module mips_regwrite_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_a,
  input  logic [ADDR_W-1:0] req_reg_a,
  input  logic [DATA_W-1:0] req_data_a,
  output logic              req_ready_a,
  input  logic              req_valid_b,
  input  logic [ADDR_W-1:0] req_reg_b,
  input  logic [DATA_W-1:0] req_data_b,
  output logic              req_ready_b,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data,
  output logic              signal_reg_write,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};

  state_t            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              last_q;   // 0 = A granted last, 1 = B granted last
  logic [ADDR_W-1:0] write_reg_q;
  logic [DATA_W-1:0] write_data_q;
  logic              wen_q;
  logic              init_done_q;
  logic              grant_a;
  logic              grant_b;

  // When both are valid, the requester that did not win last time goes first.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (state_q == ST_RUN) begin
      grant_a = req_valid_a && (!req_valid_b || last_q);
      grant_b = req_valid_b && (!req_valid_a || !last_q);
    end
  end

  assign req_ready_a      = grant_a;
  assign req_ready_b      = grant_b;
  assign write_reg        = write_reg_q;
  assign write_data       = write_data_q;
  assign signal_reg_write = wen_q;
  assign init_done        = init_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      write_reg_q  <= '0;
      write_data_q <= '0;
      wen_q        <= 1'b0;
      init_done_q  <= 1'b0;
    end else if (state_q == ST_INIT) begin
      write_reg_q  <= cnt_q;
      write_data_q <= '0;
      wen_q        <= 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_q     <= ST_RUN;
        init_done_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + ADDR_W'(1);
      end
    end else begin
      if (grant_a) begin
        write_reg_q  <= req_reg_a;
        write_data_q <= req_data_a;
        wen_q        <= 1'b1;
        last_q       <= 1'b0;
      end else if (grant_b) begin
        write_reg_q  <= req_reg_b;
        write_data_q <= req_data_b;
        wen_q        <= 1'b1;
        last_q       <= 1'b1;
      end else begin
        wen_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mips_regwrite_arbiter.sv
// tb/tb_mips_regwrite_arbiter.sv - directed self-checking bench for mips_regwrite_arbiter
module tb_mips_regwrite_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_a, req_valid_b;
  logic [2:0]  req_reg_a, req_reg_b;
  logic [31:0] req_data_a, req_data_b;
  logic        req_ready_a, req_ready_b;
  logic [2:0]  write_reg;
  logic [31:0] write_data;
  logic        signal_reg_write;
  logic        init_done;

  logic [31:0] rf [8];
  int total = 0;
  int bad = 0;

  mips_regwrite_arbiter #(.ADDR_W(3), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid_a(req_valid_a), .req_reg_a(req_reg_a), .req_data_a(req_data_a), .req_ready_a(req_ready_a),
    .req_valid_b(req_valid_b), .req_reg_b(req_reg_b), .req_data_b(req_data_b), .req_ready_b(req_ready_b),
    .write_reg(write_reg), .write_data(write_data),
    .signal_reg_write(signal_reg_write), .init_done(init_done)
  );

  always #5 clk = ~clk;

  // Behavioural stand-in for the downstream register file.
  always @(posedge clk) if (signal_reg_write) rf[write_reg] <= write_data;

  typedef struct {
    logic        va; logic [2:0] ra; logic [31:0] da;
    logic        vb; logic [2:0] rb; logic [31:0] db;
    logic        e_rdy_a; logic e_rdy_b; logic e_wen;
    logic [2:0]  e_reg; logic [31:0] e_data;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic va, input logic [2:0] ra, input logic [31:0] da,
                       input logic vb, input logic [2:0] rb, input logic [31:0] db);
    req_valid_a = va; req_reg_a = ra; req_data_a = da;
    req_valid_b = vb; req_reg_b = rb; req_data_b = db;
  endtask

  // Checks the eight clear writes following a reset release; leaves the bench just after edge R+8.
  task automatic check_clear(input string tag);
    for (int k = 0; k < 8; k++) begin
      chk({tag, "_rdy_a"}, {31'b0, req_ready_a}, 0);
      chk({tag, "_rdy_b"}, {31'b0, req_ready_b}, 0);
      step();
      chk({tag, "_wen"}, {31'b0, signal_reg_write}, 1);
      chk({tag, "_reg"}, {29'b0, write_reg}, k);
      chk({tag, "_data"}, write_data, 0);
      chk({tag, "_done"}, {31'b0, init_done}, (k == 7) ? 1 : 0);
    end
  endtask

  initial begin
    int na, nb;
    logic [31:0] va_data, vb_data;

    //            va ra    da   vb rb    db  rdyA rdyB wen reg   data
    vecs[0]  = '{1, 3'd0, 9,  0, 3'd0, 0,  1, 0, 1, 3'd0, 9};
    vecs[1]  = '{1, 3'd1, 13, 0, 3'd0, 0,  1, 0, 1, 3'd1, 13};
    vecs[2]  = '{0, 3'd0, 0,  0, 3'd0, 0,  0, 0, 0, 3'd1, 13};
    vecs[3]  = '{1, 3'd1, 13, 1, 3'd2, 5,  0, 1, 1, 3'd2, 5};
    vecs[4]  = '{1, 3'd3, 1,  1, 3'd3, 2,  1, 0, 1, 3'd3, 1};
    vecs[5]  = '{0, 3'd0, 0,  1, 3'd4, 44, 0, 1, 1, 3'd4, 44};
    vecs[6]  = '{0, 3'd0, 0,  1, 3'd6, 66, 0, 1, 1, 3'd6, 66};
    vecs[7]  = '{1, 3'd7, 70, 1, 3'd7, 71, 1, 0, 1, 3'd7, 70};
    vecs[8]  = '{1, 3'd3, 1,  1, 3'd3, 2,  0, 1, 1, 3'd3, 2};
    vecs[9]  = '{1, 3'd3, 1,  0, 3'd0, 0,  1, 0, 1, 3'd3, 1};
    vecs[10] = '{0, 3'd0, 0,  0, 3'd0, 0,  0, 0, 0, 3'd3, 1};

    // Reset with A already requesting: the request must be ignored through INIT.
    rst = 1'b1;
    drive(1, 3'd5, 77, 0, 3'd0, 0);
    step();
    step();
    rst = 1'b0;
    chk("rst_wen", {31'b0, signal_reg_write}, 0);
    chk("rst_done", {31'b0, init_done}, 0);
    chk("rst_reg", {29'b0, write_reg}, 0);
    chk("rst_data", write_data, 0);
    check_clear("init");

    for (int i = 0; i < 11; i++) begin
      drive(vecs[i].va, vecs[i].ra, vecs[i].da, vecs[i].vb, vecs[i].rb, vecs[i].db);
      #1;
      chk($sformatf("v%0d_rdy_a", i), {31'b0, req_ready_a}, {31'b0, vecs[i].e_rdy_a});
      chk($sformatf("v%0d_rdy_b", i), {31'b0, req_ready_b}, {31'b0, vecs[i].e_rdy_b});
      step();
      chk($sformatf("v%0d_wen", i), {31'b0, signal_reg_write}, {31'b0, vecs[i].e_wen});
      chk($sformatf("v%0d_reg", i), {29'b0, write_reg}, {29'b0, vecs[i].e_reg});
      chk($sformatf("v%0d_data", i), write_data, vecs[i].e_data);
    end
    chk("rf0", rf[0], 9);
    chk("rf1", rf[1], 13);
    chk("rf2", rf[2], 5);
    chk("rf3_same_dest", rf[3], 1);
    chk("rf4", rf[4], 44);
    chk("rf5_cleared", rf[5], 0);
    chk("rf6", rf[6], 66);
    chk("rf7", rf[7], 70);

    // One-cycle reset pulse clears the whole file.
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("clr_wen0", {31'b0, signal_reg_write}, 0);
    chk("clr_done0", {31'b0, init_done}, 0);
    check_clear("clr");
    step();
    chk("clr_idle_wen", {31'b0, signal_reg_write}, 0);
    for (int r = 0; r < 8; r++) chk($sformatf("clr_rf%0d", r), rf[r], 0);

    // Contention from a fresh RUN: A first, then B.
    drive(1, 3'd1, 13, 1, 3'd2, 5);
    #1;
    chk("cont_rdy_a", {31'b0, req_ready_a}, 1);
    chk("cont_rdy_b", {31'b0, req_ready_b}, 0);
    step();
    chk("cont_a_reg", {29'b0, write_reg}, 1);
    chk("cont_a_data", write_data, 13);
    drive(0, 3'd0, 0, 1, 3'd2, 5);
    #1;
    chk("cont_rdy_b2", {31'b0, req_ready_b}, 1);
    step();
    chk("cont_b_reg", {29'b0, write_reg}, 2);
    chk("cont_b_data", write_data, 5);
    drive(0, 3'd0, 0, 0, 3'd0, 0);
    step();
    chk("cont_rf1", rf[1], 13);
    chk("cont_rf2", rf[2], 5);

    // Fairness: both held valid for ten cycles, last grant was B so A leads.
    na = 0; nb = 0;
    va_data = 200; vb_data = 300;
    for (int i = 0; i < 10; i++) begin
      drive(1, 3'd4, va_data, 1, 3'd5, vb_data);
      #1;
      chk($sformatf("rr%0d_both", i), {31'b0, req_ready_a & req_ready_b}, 0);
      chk($sformatf("rr%0d_rdy_a", i), {31'b0, req_ready_a}, (i % 2 == 0) ? 1 : 0);
      step();
      chk($sformatf("rr%0d_wen", i), {31'b0, signal_reg_write}, 1);
      if (i % 2 == 0) begin
        chk($sformatf("rr%0d_data", i), write_data, va_data);
        na++; va_data++;
      end else begin
        chk($sformatf("rr%0d_data", i), write_data, vb_data);
        nb++; vb_data++;
      end
    end
    chk("rr_count_a", na, 5);
    chk("rr_count_b", nb, 5);

    // Reset lands on an accepted A write: it must never reach the file.
    drive(1, 3'd5, 123, 0, 3'd0, 0);
    #1;
    chk("mid_rdy_a", {31'b0, req_ready_a}, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_wen", {31'b0, signal_reg_write}, 0);
    chk("mid_done", {31'b0, init_done}, 0);
    check_clear("mid");
    drive(0, 3'd0, 0, 0, 3'd0, 0);
    step();
    chk("mid_rf5", rf[5], 0);
    chk("mid_rf4", rf[4], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
